// File: rtl/irq_timer_pkg.sv
// Shared types and reset constants for the irq_timer channels.
package irq_timer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        DONE
    } ch_state_e;

    localparam int unsigned RST_PERIOD = 0;
    localparam int unsigned RST_WIDTH  = 1;

endpackage

// File: rtl/irq_timer_ch.sv
// One timer channel: IDLE/COUNT/DONE counter plus interrupt pulse shaping.
// IRQ_TIMER_STICKY_EN selects sticky interrupts with ack/overrun instead of pulses.
module irq_timer_ch
    import irq_timer_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             oneshot,
    input  logic             load,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] pulse_w,
    input  logic             ack,
    output logic             inter,
    output logic             inter_nxt,
    output logic             ovf
);

    ch_state_e        state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] p_q;
    logic [CNT_W-1:0] w_q;
    logic             fire;

    assign fire = en && (state == COUNT) && (cnt == p_q);

`ifdef IRQ_TIMER_STICKY_EN
    logic [CNT_W-1:0] w_unused;
    assign w_unused = w_q;

    // A fire wins over a coincident ack so no event is lost.
    always_comb begin
        inter_nxt = inter;
        if (!en)
            inter_nxt = 1'b0;
        else if (fire)
            inter_nxt = 1'b1;
        else if (ack)
            inter_nxt = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovf <= 1'b0;
        else if (ack)
            ovf <= 1'b0;
        else if (fire && inter)
            ovf <= 1'b1;
    end
`else
    logic [CNT_W-1:0] pcnt;
    logic             ack_unused;
    assign ack_unused = ack;
    assign ovf = 1'b0;

    // pcnt holds the remaining high cycles after the current one.
    always_comb begin
        inter_nxt = inter;
        if (!en)
            inter_nxt = 1'b0;
        else if (fire)
            inter_nxt = 1'b1;
        else if (inter && (pcnt == '0))
            inter_nxt = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pcnt <= '0;
        else if (!en)
            pcnt <= '0;
        else if (fire)
            pcnt <= (w_q == '0) ? '0 : w_q - 1'b1;
        else if (pcnt != '0)
            pcnt <= pcnt - 1'b1;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            p_q   <= CNT_W'(RST_PERIOD);
            w_q   <= CNT_W'(RST_WIDTH);
            inter <= 1'b0;
        end else begin
            inter <= inter_nxt;
            if (load) begin
                p_q <= period;
                w_q <= pulse_w;
            end
            if (!en) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        state <= COUNT;
                        cnt   <= '0;
                    end
                    COUNT: begin
                        // cnt > p_q only after a shrinking load: wrap silently.
                        unique case (1'b1)
                            cnt == p_q: begin
                                cnt <= '0;
                                if (oneshot)
                                    state <= DONE;
                            end
                            cnt > p_q: cnt <= '0;
                            default:   cnt <= cnt + 1'b1;
                        endcase
                    end
                    DONE:    cnt   <= '0;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/irq_timer.sv
// Multi-channel interrupt timer: N_CH independent channels and a combined irq.
// Build with IRQ_TIMER_STICKY_EN for sticky interrupts with ack and overrun flags.
module irq_timer
    import irq_timer_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH-1:0]       en,
    input  logic [N_CH-1:0]       oneshot,
    input  logic [N_CH-1:0]       load,
    input  logic [N_CH*CNT_W-1:0] period,
    input  logic [N_CH*CNT_W-1:0] pulse_w,
    input  logic [N_CH-1:0]       ack,
    output logic [N_CH-1:0]       inter,
    output logic                  irq,
    output logic [N_CH-1:0]       ovf
);

    logic [N_CH-1:0] inter_nxt;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        irq_timer_ch #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .en       (en[c]),
            .oneshot  (oneshot[c]),
            .load     (load[c]),
            .period   (period[c*CNT_W +: CNT_W]),
            .pulse_w  (pulse_w[c*CNT_W +: CNT_W]),
            .ack      (ack[c]),
            .inter    (inter[c]),
            .inter_nxt(inter_nxt[c]),
            .ovf      (ovf[c])
        );
    end

    // Registered from the channels' next values so irq lines up with inter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            irq <= 1'b0;
        else
            irq <= |inter_nxt;
    end

endmodule

// File: tb/tb_irq_timer.sv
// Scoreboard bench for irq_timer: directed stimulus queues timed expectations,
// a negedge monitor compares inter/irq/ovf when each one falls due.
module tb_irq_timer;

    localparam int N = 4;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] en = '0;
    logic [N-1:0] oneshot = '0;
    logic [N-1:0] load = '0;
    logic [N-1:0] ack = '0;
    logic [N*W-1:0] period = '0;
    logic [N*W-1:0] pulse_w = '0;
    logic [N-1:0] inter;
    logic [N-1:0] ovf;
    logic         irq;

    typedef struct {
        int         cyc;
        string      nm;
        logic [3:0] iv;
        logic [3:0] ov;
    } exp_t;

    exp_t q[$];
    int cyc = 0;
    int base = 0;
    int nvec = 0;
    int nerr = 0;

    irq_timer #(.N_CH(N), .CNT_W(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .oneshot(oneshot),
        .load   (load),
        .period (period),
        .pulse_w(pulse_w),
        .ack    (ack),
        .inter  (inter),
        .irq    (irq),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc <= cyc) begin
                nvec++;
                if (q[i].cyc < cyc) begin
                    nerr++;
                    $display("FAIL %s: sample missed, due cycle %0d now %0d",
                             q[i].nm, q[i].cyc, cyc);
                end else if (inter !== q[i].iv || irq !== (|q[i].iv) ||
                             ovf !== q[i].ov) begin
                    nerr++;
                    $display("FAIL %s: got inter=%b irq=%b ovf=%b, want inter=%b irq=%b ovf=%b",
                             q[i].nm, inter, irq, ovf, q[i].iv, |q[i].iv, q[i].ov);
                end
                q.delete(i);
            end
        end
    end

    task automatic ex(string nm, int k, logic [3:0] iv, logic [3:0] ov = 4'b0);
        exp_t e;
        e.cyc = base + k;
        e.nm  = nm;
        e.iv  = iv;
        e.ov  = ov;
        q.push_back(e);
    endtask

    task automatic to_k(int k);
        while (cyc < base + k) @(negedge clk);
    endtask

    task automatic ld(int c, int p, int w);
        period[c*W +: W]  = W'(p);
        pulse_w[c*W +: W] = W'(w);
        load[c] = 1'b1;
        @(negedge clk);
        load[c] = 1'b0;
    endtask

    task automatic go(logic [3:0] m);
        en   = en | m;
        base = cyc + 1;
    endtask

    task automatic stop_all();
        en      = '0;
        oneshot = '0;
        ack     = '0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        @(negedge clk);
        base = cyc;
        ex("reset", 1, 4'b0000);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

`ifdef IRQ_TIMER_STICKY_EN
        // Sticky: overrun after unacked second fire, ack clears both.
        ld(0, 9, 0);
        go(4'b0001);
        ex("s_pre", 9, 4'b0000);
        ex("s_fire", 10, 4'b0001);
        ex("s_hold", 19, 4'b0001);
        ex("s_ovf", 20, 4'b0001, 4'b0001);
        ex("s_ovf_hold", 25, 4'b0001, 4'b0001);
        to_k(25);
        ack[0] = 1'b1;
        ex("s_ack", 26, 4'b0000, 4'b0000);
        @(negedge clk);
        ack[0] = 1'b0;
        ex("s_refire", 30, 4'b0001);
        to_k(39);
        ack[0] = 1'b1;
        ex("s_fire_ack", 40, 4'b0001);
        @(negedge clk);
        ack[0] = 1'b0;
        ex("s_after", 41, 4'b0001);
        to_k(42);
        stop_all();
`else
        // Periodic 115-cycle frame, W=5.
        ld(0, 114, 5);
        go(4'b0001);
        ex("a_pre", 114, 4'b0000);
        ex("a_on", 115, 4'b0001);
        ex("a_hold", 119, 4'b0001);
        ex("a_off", 120, 4'b0000);
        ex("a_rep", 230, 4'b0001);
        ex("a_rep_end", 234, 4'b0001);
        ex("a_rep_off", 235, 4'b0000);
        to_k(236);
        stop_all();

        // Oneshot P=3, rearmed by toggling en.
        ld(1, 3, 1);
        oneshot[1] = 1'b1;
        go(4'b0010);
        ex("b_pre", 3, 4'b0000);
        ex("b_fire", 4, 4'b0010);
        ex("b_off", 5, 4'b0000);
        ex("b_none", 9, 4'b0000);
        ex("b_none2", 20, 4'b0000);
        to_k(21);
        en[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        go(4'b0010);
        ex("b_rearm", 4, 4'b0010);
        ex("b_rearm_off", 5, 4'b0000);
        to_k(6);
        stop_all();

        // P=0, W=2: continuous high, cleared by en drop.
        ld(2, 0, 2);
        go(4'b0100);
        ex("c_start", 0, 4'b0000);
        ex("c_1", 1, 4'b0100);
        ex("c_5", 5, 4'b0100);
        ex("c_10", 10, 4'b0100);
        to_k(10);
        en[2] = 1'b0;
        ex("c_drop", 11, 4'b0000);
        to_k(12);
        stop_all();

        // Shrinking load wraps silently; W=0 acts as 1; ack ignored.
        ld(3, 100, 0);
        go(4'b1000);
        ack[3] = 1'b1;
        ex("d_50", 50, 4'b0000);
        to_k(50);
        ld(3, 20, 0);
        ex("d_wrap", 52, 4'b0000);
        ex("d_nofire", 53, 4'b0000);
        ex("d_72", 72, 4'b0000);
        ex("d_fire", 73, 4'b1000);
        ex("d_w0", 74, 4'b0000);
        ex("d_fire2", 94, 4'b1000);
        ex("d_off2", 95, 4'b0000);
        to_k(114);
        ld(3, 5, 0);
        ex("d_old_p", 115, 4'b1000);
        ex("d_new_p", 120, 4'b0000);
        ex("d_new_fire", 121, 4'b1000);
        to_k(122);
        stop_all();
`endif

        // Async reset mid-pulse on all channels, then restart from zero.
        period  = {N{16'd9}};
        pulse_w = {N{16'd5}};
        load    = '1;
        @(negedge clk);
        load = '0;
        go(4'b1111);
        ex("f_on", 10, 4'b1111);
        ex("f_mid", 11, 4'b1111);
        to_k(11);
        @(posedge clk);
        #2;
        rst = 1'b1;
        en  = '0;
        ex("f_async", 12, 4'b0000);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        load = '1;
        @(negedge clk);
        load = '0;
        go(4'b1111);
        ex("f_re_pre", 9, 4'b0000);
        ex("f_re_fire", 10, 4'b1111);
        to_k(11);
        stop_all();

        repeat (5) @(negedge clk);
        if (q.size() != 0) begin
            $display("FAIL drain: got %0d pending, want 0", q.size());
            nvec++;
            nerr++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
